// File: rtl/gshare_predictor_pkg.sv
// Shared types for the branch predictor: LC-3b word and 2-bit counter encodings,
// plus the predictor FSM states and the saturating counter step.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  pht_cnt_t;

  localparam pht_cnt_t SNT = 2'b00;
  localparam pht_cnt_t WNT = 2'b01;
  localparam pht_cnt_t WT  = 2'b10;
  localparam pht_cnt_t ST  = 2'b11;
endpackage

package gshare_predictor_pkg;
  import lc3b_types::*;

  typedef enum logic {INIT, RUN} pred_state_t;

  // Moves a counter one step towards taken (up=1) or not taken, clamping at the ends.
  function automatic pht_cnt_t sat_step(input pht_cnt_t cnt, input logic up);
    if (up) return (cnt == ST) ? ST : cnt + 2'b01;
    return (cnt == SNT) ? SNT : cnt - 2'b01;
  endfunction
endpackage

// File: rtl/gshare_predictor_if.sv
// IF-stage lookup and WB-stage update signals of the predictor, bundled as one port.
interface gshare_predictor_if #(
  parameter int num_addr_bits = 5,
  parameter int cnt_width     = 16
);
  import lc3b_types::*;

  lc3b_word                 mem_address_IF;
  logic                     br_instruction;
  logic                     prediction;
  logic [num_addr_bits-1:0] pred_index_IF;
  logic [num_addr_bits-1:0] update_index_WB;
  logic                     taken;
  logic                     not_taken;
  logic                     mispredict;
  logic                     ready;
  logic [cnt_width-1:0]     br_count;
  logic [cnt_width-1:0]     mispred_count;

  modport master (
    output mem_address_IF, br_instruction, update_index_WB, taken, not_taken, mispredict,
    input  prediction, pred_index_IF, ready, br_count, mispred_count
  );

  modport slave (
    input  mem_address_IF, br_instruction, update_index_WB, taken, not_taken, mispredict,
    output prediction, pred_index_IF, ready, br_count, mispred_count
  );
endinterface

// File: rtl/gshare_predictor_branch_pht.sv
// Pattern history table: combinational read, saturating update port, and a direct
// write that the predictor uses to sweep every entry to weakly-not-taken.
module branch_pht
  import lc3b_types::*, gshare_predictor_pkg::*;
#(
  parameter int addr_bits = 5
) (
  input  logic                 clk,
  input  logic [addr_bits-1:0] read_index,
  output pht_cnt_t             read_value,
  input  logic [addr_bits-1:0] write_index,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 init_we,
  input  logic [addr_bits-1:0] init_index
);

  pht_cnt_t entries [2**addr_bits];

  assign read_value = entries[read_index];

  // The init sweep and branch updates never coincide; inc and dec together means no update.
  always_ff @(posedge clk) begin
    if (init_we) begin
      entries[init_index] <= WNT;
    end else if (inc ^ dec) begin
      entries[write_index] <= sat_step(entries[write_index], inc);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch predictor: init sweep FSM, resolved global history,
// PC/history index hashing and saturating performance counters around branch_pht.
module gshare_predictor
  import lc3b_types::*, gshare_predictor_pkg::*;
#(
  parameter int num_addr_bits = 5,
  parameter int hist_bits     = 5,
  parameter int gshare_mode   = 1,
  parameter int cnt_width     = 16
) (
  input logic               clk,
  input logic               rst,
  gshare_predictor_if.slave bus
);

  pred_state_t              state;
  pred_state_t              state_next;
  logic [num_addr_bits-1:0] sweep_index;
  logic [num_addr_bits-1:0] lookup_index;
  logic [num_addr_bits-1:0] pc_bits;
  logic [num_addr_bits-1:0] ghr_ext;
  logic [hist_bits-1:0]     ghr;
  logic                     init_we;
  logic                     ready;
  logic                     update_valid;
  logic                     unused_bits;
  pht_cnt_t                 lookup_value;
  logic [cnt_width-1:0]     br_count;
  logic [cnt_width-1:0]     mispred_count;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    init_we    = 1'b0;
    ready      = 1'b0;
    case (state)
      INIT: begin
        init_we = 1'b1;
        if (sweep_index == '1) state_next = RUN;
      end
      RUN: ready = 1'b1;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                sweep_index <= '0;
    else if (state == INIT) sweep_index <= sweep_index + num_addr_bits'(1);
  end

  // Only a lone taken or not_taken pulse in RUN is a real resolution.
  assign update_valid = ready && !rst && (bus.taken ^ bus.not_taken);

  always_ff @(posedge clk) begin
    if (rst)               ghr <= '0;
    else if (update_valid) ghr <= hist_bits'({ghr, bus.taken});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (update_valid) begin
      if (br_count != '1) br_count <= br_count + cnt_width'(1);
      if (bus.mispredict && mispred_count != '1) mispred_count <= mispred_count + cnt_width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.taken && bus.not_taken))
        else $warning("gshare_predictor: taken and not_taken together, update dropped");
    end
  end

  always_comb begin
    ghr_ext                = '0;
    ghr_ext[hist_bits-1:0] = ghr;
    pc_bits                = bus.mem_address_IF[num_addr_bits:1];
    lookup_index           = (gshare_mode != 0) ? (pc_bits ^ ghr_ext) : pc_bits;
  end

  branch_pht #(.addr_bits(num_addr_bits)) pht (
    .clk         (clk),
    .read_index  (lookup_index),
    .read_value  (lookup_value),
    .write_index (bus.update_index_WB),
    .inc         (update_valid && bus.taken),
    .dec         (update_valid && bus.not_taken),
    .init_we     (init_we),
    .init_index  (sweep_index)
  );

  assign bus.prediction    = lookup_value[1] & bus.br_instruction & ready;
  assign bus.pred_index_IF = lookup_index;
  assign bus.ready         = ready;
  assign bus.br_count      = br_count;
  assign bus.mispred_count = mispred_count;

  assign unused_bits = ^{bus.mem_address_IF[15:num_addr_bits+1], bus.mem_address_IF[0], lookup_value[0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench: a gshare instance (16-bit counters) and a bimodal instance
// (2-bit counters) driven side by side with hand-computed expectations.
module tb_gshare_predictor;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;

  gshare_predictor_if #(.num_addr_bits(5), .cnt_width(16)) g_bus ();
  gshare_predictor_if #(.num_addr_bits(5), .cnt_width(2))  b_bus ();

  gshare_predictor #(.num_addr_bits(5), .hist_bits(5), .gshare_mode(1), .cnt_width(16)) dut_g (
    .clk (clk),
    .rst (rst),
    .bus (g_bus)
  );

  gshare_predictor #(.num_addr_bits(5), .hist_bits(5), .gshare_mode(0), .cnt_width(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Presents one WB resolution for a single clock, then returns to idle at the next negedge.
  task automatic updateG(input logic t, input logic nt, input logic mp, input logic [4:0] idx);
    g_bus.update_index_WB = idx;
    g_bus.taken = t;
    g_bus.not_taken = nt;
    g_bus.mispredict = mp;
    @(negedge clk);
    g_bus.taken = 1'b0;
    g_bus.not_taken = 1'b0;
    g_bus.mispredict = 1'b0;
  endtask

  task automatic updateB(input logic t, input logic nt, input logic [4:0] idx);
    b_bus.update_index_WB = idx;
    b_bus.taken = t;
    b_bus.not_taken = nt;
    b_bus.mispredict = 1'b0;
    @(negedge clk);
    b_bus.taken = 1'b0;
    b_bus.not_taken = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] pc_g, input logic [15:0] pc_b);
    g_bus.mem_address_IF = pc_g;
    g_bus.br_instruction = 1'b1;
    b_bus.mem_address_IF = pc_b;
    b_bus.br_instruction = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    g_bus.mem_address_IF = 16'h0; g_bus.br_instruction = 1'b0; g_bus.update_index_WB = '0;
    g_bus.taken = 1'b0; g_bus.not_taken = 1'b0; g_bus.mispredict = 1'b0;
    b_bus.mem_address_IF = 16'h0; b_bus.br_instruction = 1'b0; b_bus.update_index_WB = '0;
    b_bus.taken = 1'b0; b_bus.not_taken = 1'b0; b_bus.mispredict = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'h0006, 16'h0010);
    checkOutput("rst_ready_g", g_bus.ready, 0);
    checkOutput("rst_ready_b", b_bus.ready, 0);
    checkOutput("rst_brcnt_g", g_bus.br_count, 0);
    checkOutput("rst_miscnt_g", g_bus.mispred_count, 0);
    checkOutput("rst_pred_g", g_bus.prediction, 0);
    checkOutput("rst_index_g", g_bus.pred_index_IF, 5'd3);

    n = 0;
    while (g_bus.ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("init_cycles", n, 32);
    checkOutput("init_ready_b", b_bus.ready, 1);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(16'(i * 2), 16'(i * 2));
      checkOutput("default_pred_g", g_bus.prediction, 0);
      checkOutput("default_pred_b", b_bus.prediction, 0);
      @(negedge clk);
    end

    applyStimulus(16'h0000, 16'h0010);
    checkOutput("bimodal_index", b_bus.pred_index_IF, 5'd8);
    repeat (3) updateB(1'b1, 1'b0, 5'd8);
    applyStimulus(16'h0000, 16'h0010);
    checkOutput("sat_st_pred", b_bus.prediction, 1);
    updateB(1'b1, 1'b0, 5'd8);
    updateB(1'b0, 1'b1, 5'd8);
    applyStimulus(16'h0000, 16'h0010);
    checkOutput("sat_top_hold", b_bus.prediction, 1);
    checkOutput("brcnt_sat_2bit", b_bus.br_count, 3);
    checkOutput("miscnt_b", b_bus.mispred_count, 0);
    repeat (3) updateB(1'b0, 1'b1, 5'd8);
    applyStimulus(16'h0000, 16'h0010);
    checkOutput("sat_snt_pred", b_bus.prediction, 0);
    updateB(1'b0, 1'b1, 5'd8);
    updateB(1'b1, 1'b0, 5'd8);
    applyStimulus(16'h0000, 16'h0010);
    checkOutput("sat_bottom_hold", b_bus.prediction, 0);
    updateB(1'b1, 1'b0, 5'd8);
    applyStimulus(16'h0000, 16'h0010);
    checkOutput("wnt_to_wt", b_bus.prediction, 1);

    b_bus.mem_address_IF = 16'h0006;
    b_bus.update_index_WB = 5'd3;
    b_bus.taken = 1'b1;
    #1;
    checkOutput("rbw_index", b_bus.pred_index_IF, 5'd3);
    checkOutput("rbw_same_cycle", b_bus.prediction, 0);
    @(negedge clk);
    b_bus.taken = 1'b0;
    #1;
    checkOutput("rbw_next_cycle", b_bus.prediction, 1);

    updateG(1'b1, 1'b0, 1'b1, 5'd0);
    repeat (3) updateG(1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    checkOutput("brcnt_4", g_bus.br_count, 4);
    checkOutput("miscnt_1", g_bus.mispred_count, 1);
    updateG(1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(16'h0006, 16'h0000);
    checkOutput("brcnt_5", g_bus.br_count, 5);
    checkOutput("gshare_index", g_bus.pred_index_IF, 5'h1C);
    checkOutput("gshare_pred_cold", g_bus.prediction, 0);
    applyStimulus(16'h003E, 16'h0000);
    checkOutput("gshare_index0", g_bus.pred_index_IF, 5'h00);
    checkOutput("gshare_pred_hot", g_bus.prediction, 1);
    g_bus.br_instruction = 1'b0;
    #1;
    checkOutput("non_branch_pred", g_bus.prediction, 0);

    updateG(1'b0, 1'b0, 1'b1, 5'd0);
    #1;
    checkOutput("lone_mispred_br", g_bus.br_count, 5);
    checkOutput("lone_mispred_mis", g_bus.mispred_count, 1);
    updateG(1'b1, 1'b1, 1'b1, 5'd0);
    applyStimulus(16'h0006, 16'h0000);
    checkOutput("illegal_br", g_bus.br_count, 5);
    checkOutput("illegal_mis", g_bus.mispred_count, 1);
    checkOutput("illegal_ghr", g_bus.pred_index_IF, 5'h1C);
    updateG(1'b0, 1'b1, 1'b1, 5'd5);
    applyStimulus(16'h0006, 16'h0000);
    checkOutput("nt_ghr_shift", g_bus.pred_index_IF, 5'h1D);
    checkOutput("nt_brcnt", g_bus.br_count, 6);
    checkOutput("nt_miscnt", g_bus.mispred_count, 2);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    g_bus.update_index_WB = 5'd0;
    g_bus.taken = 1'b1;
    g_bus.mispredict = 1'b1;
    applyStimulus(16'h0006, 16'h0010);
    checkOutput("midrst_ready_g", g_bus.ready, 0);
    checkOutput("midrst_ready_b", b_bus.ready, 0);
    checkOutput("midrst_br_g", g_bus.br_count, 0);
    checkOutput("midrst_mis_g", g_bus.mispred_count, 0);
    checkOutput("midrst_br_b", b_bus.br_count, 0);
    checkOutput("midrst_ghr", g_bus.pred_index_IF, 5'd3);
    n = 0;
    while (g_bus.ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    g_bus.taken = 1'b0;
    g_bus.mispredict = 1'b0;
    checkOutput("midrst_cycles", n, 32);
    applyStimulus(16'h0006, 16'h0010);
    checkOutput("init_upd_br", g_bus.br_count, 0);
    checkOutput("init_upd_ghr", g_bus.pred_index_IF, 5'd3);
    checkOutput("resweep_pred_b", b_bus.prediction, 0);
    applyStimulus(16'h0000, 16'h0006);
    checkOutput("resweep_pred_g0", g_bus.prediction, 0);
    checkOutput("resweep_pred_b3", b_bus.prediction, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
